// File: rtl/dcache_pkg.sv
// Shared types and field widths for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam int TAG_W   = 3;
    localparam int IDX_W   = 3;
    localparam int OFF_W   = 2;
    localparam int BLOCK_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH
    } state_e;

    function automatic logic [7:0] byte_of(input logic [BLOCK_W-1:0] block,
                                           input logic [OFF_W-1:0]   offset);
        return block[{offset, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dcache_store.sv
// Line storage: data/tag arrays plus valid/dirty bits, which clear asynchronously.
module dcache_store
    import dcache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [BLOCK_W-1:0] data_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic               valid_o,
    output logic               dirty_o,
    input  logic               byte_we_i,
    input  logic [OFF_W-1:0]   off_i,
    input  logic [7:0]         byte_i,
    input  logic               fill_we_i,
    input  logic [TAG_W-1:0]   fill_tag_i,
    input  logic [BLOCK_W-1:0] fill_data_i
);

    logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;

    assign data_o  = data_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];

    // Contents are don't-care after reset, so the arrays carry no reset.
    always_ff @(posedge clk_i) begin
        if (fill_we_i) begin
            data_q[idx_i] <= fill_data_i;
            tag_q[idx_i]  <= fill_tag_i;
        end else if (byte_we_i) begin
            data_q[idx_i][{off_i, 3'b000} +: 8] <= byte_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (byte_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the ALU and a
// block-wide data memory; stalls the CPU through BUSYWAIT while a miss is served.
module data_cache
    import dcache_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int NUM_BLOCKS  = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     READ,
    input  logic                     WRITE,
    input  logic [ADDR_W-1:0]        ADDRESS,
    input  logic [7:0]               WRITEDATA,
    output logic [7:0]               READDATA,
    output logic                     BUSYWAIT,
    output logic                     MEM_READ,
    output logic                     MEM_WRITE,
    output logic [ADDR_W-3:0]        MEM_ADDRESS,
    output logic [8*BLOCK_BYTES-1:0] MEM_WRITEDATA,
    input  logic [8*BLOCK_BYTES-1:0] MEM_READDATA,
    input  logic                     MEM_BUSYWAIT
);

    state_e             state_q;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic [OFF_W-1:0]   req_off;
    logic [BLOCK_W-1:0] line_data;
    logic [TAG_W-1:0]   line_tag;
    logic               line_valid;
    logic               line_dirty;
    logic               req;
    logic               hit;
    logic               byte_we;
    logic               fill_we;

    assign req_tag = ADDRESS[7:5];
    assign req_idx = ADDRESS[4:2];
    assign req_off = ADDRESS[1:0];
    assign req     = READ || WRITE;
    assign hit     = line_valid && (line_tag == req_tag);

    dcache_store #(
        .NUM_BLOCKS(NUM_BLOCKS)
    ) u_store (
        .clk_i      (CLK),
        .rst_ni     (RESET_N),
        .idx_i      (req_idx),
        .data_o     (line_data),
        .tag_o      (line_tag),
        .valid_o    (line_valid),
        .dirty_o    (line_dirty),
        .byte_we_i  (byte_we),
        .off_i      (req_off),
        .byte_i     (WRITEDATA),
        .fill_we_i  (fill_we),
        .fill_tag_i (req_tag),
        .fill_data_i(MEM_READDATA)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && !hit)
                        state_q <= (line_valid && line_dirty) ? WRITEBACK : FETCH;
                end
                WRITEBACK: begin
                    if (!MEM_BUSYWAIT)
                        state_q <= FETCH;
                end
                FETCH: begin
                    if (!MEM_BUSYWAIT)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from the state so read hits complete with no added
    // latency; gating on RESET_N drops strobes and stall as soon as reset asserts.
    always_comb begin
        READDATA      = '0;
        BUSYWAIT      = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        byte_we       = 1'b0;
        fill_we       = 1'b0;
        if (RESET_N) begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (!hit)
                            BUSYWAIT = 1'b1;
                        else if (WRITE)
                            byte_we = 1'b1;
                        else
                            READDATA = byte_of(line_data, req_off);
                    end
                end
                WRITEBACK: begin
                    BUSYWAIT      = 1'b1;
                    MEM_WRITE     = 1'b1;
                    MEM_ADDRESS   = {line_tag, req_idx};
                    MEM_WRITEDATA = line_data;
                end
                FETCH: begin
                    BUSYWAIT    = 1'b1;
                    MEM_READ    = 1'b1;
                    MEM_ADDRESS = {req_tag, req_idx};
                    fill_we     = !MEM_BUSYWAIT;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: a flat byte-memory reference model predicts
// load data, stall lengths and memory block transactions; monitors compare.
module tb_data_cache;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [7:0]  ADDRESS = '0;
    logic [7:0]  WRITEDATA = '0;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    always #5 CLK = ~CLK;

    data_cache #(
        .ADDR_W(8),
        .NUM_BLOCKS(8),
        .BLOCK_BYTES(4)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .READ         (READ),
        .WRITE        (WRITE),
        .ADDRESS      (ADDRESS),
        .WRITEDATA    (WRITEDATA),
        .READDATA     (READDATA),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Block memory: latency of lat cycles, busy low only in the completing cycle.
    logic [31:0] mem [64];
    int lat = 4;
    int mcnt = 0;
    assign MEM_READDATA = mem[MEM_ADDRESS];
    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mcnt != lat - 1);

    always @(posedge CLK) begin
        if (MEM_READ || MEM_WRITE) begin
            if (mcnt == lat - 1) begin
                if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
                mcnt <= 0;
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    // Reference model: coherent byte view plus which block each line holds.
    logic [7:0] flat [256];
    logic [2:0] mtag [8];
    bit         mvalid [8];
    bit         mdirty [8];

    typedef struct {
        bit         is_read;
        logic [7:0] data;
        int         stall;
    } acc_t;
    typedef struct {
        bit          is_write;
        logic [5:0]  addr;
        logic [31:0] data;
    } mtx_t;

    acc_t accq[$];
    mtx_t mtxq[$];

    function automatic logic [31:0] blk(input logic [5:0] b);
        return {flat[{b, 2'd3}], flat[{b, 2'd2}], flat[{b, 2'd1}], flat[{b, 2'd0}]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mvalid[i] = 0;
            mdirty[i] = 0;
        end
        for (int b = 0; b < 64; b++) begin
            logic [31:0] w;
            w = mem[b];
            for (int k = 0; k < 4; k++) flat[b*4+k] = w[8*k +: 8];
        end
    endtask

    task automatic predict(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
        logic [2:0] i;
        logic [2:0] t;
        acc_t e;
        mtx_t m;
        i = a[4:2];
        t = a[7:5];
        e.stall = 0;
        if (!(mvalid[i] && mtag[i] == t)) begin
            e.stall = 1 + lat;
            if (mvalid[i] && mdirty[i]) begin
                m.is_write = 1;
                m.addr = {mtag[i], i};
                m.data = blk({mtag[i], i});
                mtxq.push_back(m);
                e.stall += lat;
            end
            m.is_write = 0;
            m.addr = a[7:2];
            m.data = '0;
            mtxq.push_back(m);
            mvalid[i] = 1;
            mtag[i] = t;
            mdirty[i] = 0;
        end
        e.is_read = rd && !wr;
        e.data = flat[a];
        if (wr) begin
            flat[a] = d;
            mdirty[i] = 1;
        end
        accq.push_back(e);
    endtask

    task automatic access(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
        int n;
        predict(rd, wr, a, d);
        READ = rd;
        WRITE = wr;
        ADDRESS = a;
        WRITEDATA = d;
        n = 0;
        forever begin
            @(negedge CLK);
            if (!BUSYWAIT) break;
            n++;
            if (n > 100) begin
                n_checks++;
                $display("FAIL busywait_timeout: addr 0x%0h still stalled after %0d cycles", a, n);
                break;
            end
        end
        @(posedge CLK);
        #1;
        READ = 0;
        WRITE = 0;
    endtask

    task automatic reset_mid_fetch(input logic [7:0] a);
        int n;
        predict(1, 0, a, 8'h00);
        READ = 1;
        ADDRESS = a;
        n = 0;
        forever begin
            @(negedge CLK);
            if (MEM_READ) break;
            n++;
            if (n > 50) begin
                n_checks++;
                $display("FAIL fetch_timeout: no MEM_READ for 0x%0h", a);
                break;
            end
        end
        #2;
        RESET_N = 0;
        #1;
        chk("rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
        chk("rst_mem_read", {31'd0, MEM_READ}, 32'd0);
        chk("rst_mem_write", {31'd0, MEM_WRITE}, 32'd0);
        chk("rst_mem_addr", {26'd0, MEM_ADDRESS}, 32'd0);
        READ = 0;
        accq.delete();
        mtxq.delete();
        @(posedge CLK);
        @(posedge CLK);
        #3;
        RESET_N = 1;
        model_reset();
        @(posedge CLK);
        #1;
    endtask

    // Monitors: CPU completions and memory transaction starts.
    int   stall_cnt = 0;
    bit   prev_r = 0;
    bit   prev_w = 0;
    acc_t mon_e;
    mtx_t mon_m;

    always @(negedge CLK) begin
        if (!RESET_N) begin
            stall_cnt = 0;
            prev_r = 0;
            prev_w = 0;
        end else begin
            if (READ || WRITE) begin
                if (BUSYWAIT) begin
                    stall_cnt++;
                end else begin
                    if (accq.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_completion: addr 0x%0h", ADDRESS);
                    end else begin
                        mon_e = accq.pop_front();
                        if (mon_e.is_read) chk("readdata", {24'd0, READDATA}, {24'd0, mon_e.data});
                        chk("stall_cycles", stall_cnt, mon_e.stall);
                    end
                    stall_cnt = 0;
                end
            end
            if ((MEM_WRITE && !prev_w) || (MEM_READ && !prev_r)) begin
                if (mtxq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_mem_txn: addr 0x%0h write %0b", MEM_ADDRESS, MEM_WRITE);
                end else begin
                    mon_m = mtxq.pop_front();
                    chk("mem_is_write", {31'd0, MEM_WRITE}, {31'd0, mon_m.is_write});
                    chk("mem_strobe_excl", {31'd0, MEM_READ && MEM_WRITE}, 32'd0);
                    chk("mem_addr", {26'd0, MEM_ADDRESS}, {26'd0, mon_m.addr});
                    if (mon_m.is_write) chk("mem_wdata", MEM_WRITEDATA, mon_m.data);
                end
            end
            prev_r = MEM_READ;
            prev_w = MEM_WRITE;
        end
    end

    initial begin
        for (int b = 0; b < 64; b++) mem[b] = $urandom;
        mem[0] = 32'h44332211;
        model_reset();

        READ = 1;
        #12;
        chk("reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
        chk("reset_readdata", {24'd0, READDATA}, 32'd0);
        chk("reset_mem_read", {31'd0, MEM_READ}, 32'd0);
        chk("reset_mem_write", {31'd0, MEM_WRITE}, 32'd0);
        chk("reset_mem_addr", {26'd0, MEM_ADDRESS}, 32'd0);
        chk("reset_mem_wdata", MEM_WRITEDATA, 32'd0);
        READ = 0;
        #10;
        RESET_N = 1;
        @(posedge CLK);
        #1;

        lat = 4;
        access(1, 0, 8'h00, 8'h00);
        access(1, 0, 8'h03, 8'h00);
        access(0, 1, 8'h02, 8'hAB);
        access(1, 0, 8'h02, 8'h00);
        access(1, 0, 8'h20, 8'h00);
        access(1, 0, 8'h40, 8'h00);
        access(1, 0, 8'h21, 8'h00);
        access(1, 1, 8'h21, 8'h5A);
        access(1, 0, 8'h21, 8'h00);
        access(1, 0, 8'h41, 8'h00);
        reset_mid_fetch(8'h84);
        access(1, 0, 8'h41, 8'h00);

        for (int n = 0; n < 400; n++) begin
            int op;
            logic [7:0] a;
            lat = $urandom_range(2, 5);
            op = $urandom_range(0, 3);
            a = 8'($urandom);
            if (op == 0) begin
                @(posedge CLK);
                #1;
            end else begin
                access(op != 2, op != 1, a, 8'($urandom));
            end
        end

        repeat (3) @(posedge CLK);
        #1;
        chk("acc_queue_empty", accq.size(), 32'd0);
        chk("mem_queue_empty", mtxq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
Direct-mapped, write-back, write-allocate data cache. It sits directly downstream of the ALU: ALURESULT is ADDRESS for lwd/lwi/swd/swi, and REGOUT2 is WRITEDATA. It serves CPU byte accesses from an 8-block x 4-byte array. On a miss it stalls the CPU via BUSYWAIT while it talks to the block-wide data memory.

Parameters:
ADDR_W, 8, CPU byte-address width
NUM_BLOCKS, 8, number of cache lines (index width = log2 = 3)
BLOCK_BYTES, 4, bytes per line (offset width = 2); tag width = ADDR_W-5 = 3
Only the defaults are supported. The parameters exist for readability, not for scaling.

Ports:
CLK  in  1  clock, rising-edge
RESET_N  in  1  asynchronous reset, active-low
READ  in  1  CPU load request (level, held until BUSYWAIT low at an edge)
WRITE  in  1  CPU store request (level, same rule)
ADDRESS  in  8  byte address {tag[7:5], index[4:2], offset[1:0]}
WRITEDATA  in  8  store data
READDATA  out  8  load data
BUSYWAIT  out  1  stall to CPU
MEM_READ  out  1  memory block read strobe
MEM_WRITE  out  1  memory block write strobe
MEM_ADDRESS  out  6  block address {tag,index}
MEM_WRITEDATA  out  32  victim block, byte k at [8k+7:8k]
MEM_READDATA  in  32  fetched block, same byte order
MEM_BUSYWAIT  in  1  memory stall

Behaviour:
Interface: one clock; reset is asynchronous and active-low.

Storage: per line data[31:0], tag[2:0], valid, dirty.

Reset (RESET_N=0, any time, including mid-miss):
- All valid and dirty bits clear; state goes to IDLE.
- MEM_READ=0, MEM_WRITE=0, BUSYWAIT=0, READDATA=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
- Data and tag contents are don't-care.

Request decode:
- hit = valid[idx] && tag[idx]==ADDRESS[7:5].
- If READ and WRITE are both high, WRITE wins and READ is ignored.

States: IDLE, WRITEBACK, FETCH.

IDLE:
- No request: BUSYWAIT=0, READDATA=0.
- Read hit: BUSYWAIT=0 combinationally and READDATA = selected byte in the same cycle. Zero added latency.
- Write hit: BUSYWAIT=0. At the rising edge the selected byte is updated and dirty[idx] is set.
- Miss: BUSYWAIT=1 combinationally. At the next edge go to WRITEBACK if valid && dirty, otherwise to FETCH.

WRITEBACK:
- MEM_WRITE=1, MEM_ADDRESS={stored tag, idx}, MEM_WRITEDATA=data[idx], BUSYWAIT=1.
- At the edge where MEM_BUSYWAIT==0, go to FETCH.

FETCH:
- MEM_READ=1, MEM_ADDRESS={ADDRESS tag, idx}, BUSYWAIT=1.
- At the edge where MEM_BUSYWAIT==0: data[idx]=MEM_READDATA, tag updated, valid=1, dirty=0, state to IDLE.
- The access then completes as a hit in the following cycle.
- Miss latency = 1 + (writeback cycles) + (fetch cycles) + 1 hit cycle.

Memory contract:
- MEM_BUSYWAIT is high in the same cycle a strobe rises.
- It is low for exactly the completing cycle, with MEM_READDATA valid in that cycle.
- The strobes drop the cycle after completion and never assert together.

CPU contract:
- ADDRESS, WRITEDATA, READ and WRITE are held stable while BUSYWAIT=1.
- Violations are unspecified behaviour, not checked.

Boundaries:
- Offset 3 selects byte [31:24].
- A clean valid miss skips WRITEBACK.
- An invalid line with a stale dirty bit cannot occur, because dirty is only set on a valid line.
- Back-to-back hits to different indices complete one per cycle.

Decomposition:
Package dcache_pkg holds:
- state enum {IDLE, WRITEBACK, FETCH}
- TAG_W=3, IDX_W=3, OFF_W=2
- a byte-select function byte_of(block, offset)

One sub-module, dcache_store, holds the data/tag/valid/dirty arrays. It has a combinational read port, a synchronous byte-write port and a synchronous line-fill port, and asynchronous clear of the valid/dirty bits.

The FSM and hit logic stay in data_cache.

Test Plan:
1. Reset, then READ 0x00 with a memory model of 4-cycle latency where block 0 = 0x44332211 -> BUSYWAIT high, one FETCH with MEM_ADDRESS=0x00 and no MEM_WRITE. Then READDATA=0x11, and READ 0x03 hits at once with 0x44.
2. WRITE 0xAB to 0x02 on the resident line -> zero stall, dirty set. A following READ 0x02 returns 0xAB with BUSYWAIT low throughout.
3. Dirty eviction: after case 2, READ 0x20 (same index 0, tag 1) -> WRITEBACK with MEM_ADDRESS=0x00 and MEM_WRITEDATA=0x44AB2211, then FETCH with MEM_ADDRESS=0x08, then the hit.
4. Clean eviction: READ 0x40 after case 3 -> FETCH only, with MEM_WRITE never asserted.
5. Reset asserted during FETCH -> strobes and BUSYWAIT drop immediately. A subsequent READ of the previously resident address misses.
6. READ and WRITE both high to hit address 0x21 with data 0x5A -> treated as a write: byte updated and dirty set.
